// File: rtl/kws_framer.sv
// Overlapping-frame builder for the KWS front end: circular sample buffer,
// FRAME_LEN-sample frames advancing by HOP_LEN, zero-padded to PAD_LEN.
module kws_framer #(
  parameter int unsigned DATA_WDTH  = 20,
  parameter int unsigned FRAME_LEN  = 512,
  parameter int unsigned HOP_LEN    = 256,
  parameter int unsigned PAD_LEN    = 1024,
  parameter int unsigned ADDR_WDTH  = 10,
  parameter int unsigned NUM_FRAMES = 49,
  parameter int unsigned NUM_WDTH   = 10,
  parameter int unsigned FRM_WDTH   = 6
) (
  input  logic                        i_clk,
  input  logic                        i_rst,
  input  logic                        i_start,
  input  logic signed [DATA_WDTH-1:0] i_in,
  input  logic                        i_in_valid,
  output logic                        o_in_ready,
  output logic signed [DATA_WDTH-1:0] o_out,
  output logic                        o_out_valid,
  input  logic                        i_out_ready,
  output logic [NUM_WDTH-1:0]         o_out_num,
  output logic                        o_out_last,
  output logic [FRM_WDTH-1:0]         o_frame_num,
  output logic [2:0]                  o_out_state
);

  localparam int unsigned DEPTH = 1 << ADDR_WDTH;
  localparam int unsigned SW    = ADDR_WDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_FILL = 3'd1,
    S_EMIT = 3'd2,
    S_PAD  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t                       r_state;
  state_t                       w_state_nxt;
  logic signed [DATA_WDTH-1:0]  r_mem [DEPTH];
  logic [ADDR_WDTH-1:0]         r_wr_ptr;
  logic [ADDR_WDTH-1:0]         r_base;
  logic [SW-1:0]                r_stored;
  logic [NUM_WDTH-1:0]          r_idx;
  logic                         r_issue_done;
  logic                         r_in_ready;
  logic signed [DATA_WDTH-1:0]  r_out;
  logic                         r_out_valid;
  logic [NUM_WDTH-1:0]          r_out_num;
  logic                         r_out_last;
  logic [FRM_WDTH-1:0]          r_frame_num;

  logic                         w_accept;
  logic                         w_adv;
  logic                         w_issue;
  logic                         w_xfer_last;
  logic                         w_arm;
  logic                         w_idx_last;
  logic                         w_ready_nxt;
  logic [SW-1:0]                w_stored_nxt;
  logic [FRM_WDTH-1:0]          w_frm_inc;
  logic [ADDR_WDTH-1:0]         w_rd_addr;

  assign w_accept     = i_in_valid && r_in_ready;
  assign w_adv        = !r_out_valid || i_out_ready;
  assign w_issue      = w_adv && !r_issue_done && (r_state == S_EMIT || r_state == S_PAD);
  assign w_xfer_last  = r_out_valid && i_out_ready && r_out_last;
  assign w_arm        = i_start && (r_state == S_IDLE || r_state == S_DONE);
  assign w_idx_last   = (r_idx == NUM_WDTH'(PAD_LEN - 1));
  assign w_frm_inc    = r_frame_num + FRM_WDTH'(1);
  assign w_rd_addr    = r_base + ADDR_WDTH'(r_idx);
  assign w_stored_nxt = r_stored + SW'(w_accept) - (w_xfer_last ? SW'(HOP_LEN) : SW'(0));

  // Next state; frame completion overrides the per-state decision
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE: if (i_start) w_state_nxt = S_FILL;
      S_FILL:         if (r_stored >= SW'(FRAME_LEN)) w_state_nxt = S_EMIT;
      S_EMIT:         if (w_issue && !w_idx_last && r_idx == NUM_WDTH'(FRAME_LEN - 1))
                        w_state_nxt = S_PAD;
      default:        w_state_nxt = r_state;
    endcase
    if (w_xfer_last) begin
      if (NUM_FRAMES != 0 && w_frm_inc == FRM_WDTH'(NUM_FRAMES))
        w_state_nxt = S_DONE;
      else if (w_stored_nxt >= SW'(FRAME_LEN))
        w_state_nxt = S_EMIT;
      else
        w_state_nxt = S_FILL;
    end
  end

  assign w_ready_nxt = (w_state_nxt == S_FILL || w_state_nxt == S_EMIT || w_state_nxt == S_PAD)
                       && (w_arm || (w_stored_nxt < SW'(DEPTH)));

  // Sample buffer write port
  always_ff @(posedge i_clk) begin
    if (w_accept) r_mem[r_wr_ptr] <= i_in;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_wr_ptr     <= '0;
      r_base       <= '0;
      r_stored     <= '0;
      r_idx        <= '0;
      r_issue_done <= 1'b0;
      r_in_ready   <= 1'b0;
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_out_num    <= '0;
      r_out_last   <= 1'b0;
      r_frame_num  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_in_ready <= w_ready_nxt;
      if (w_arm) begin
        r_wr_ptr     <= '0;
        r_base       <= '0;
        r_stored     <= '0;
        r_idx        <= '0;
        r_issue_done <= 1'b0;
        r_frame_num  <= '0;
      end else begin
        if (w_accept) r_wr_ptr <= r_wr_ptr + ADDR_WDTH'(1);
        r_stored <= w_stored_nxt;
        if (w_xfer_last) begin
          r_base       <= r_base + ADDR_WDTH'(HOP_LEN);
          r_frame_num  <= w_frm_inc;
          r_idx        <= '0;
          r_issue_done <= 1'b0;
        end else if (w_issue) begin
          if (w_idx_last) r_issue_done <= 1'b1;
          else            r_idx        <= r_idx + NUM_WDTH'(1);
        end
      end
      // Output stage doubles as the RAM read register and stalls as a unit
      if (w_adv) begin
        r_out_valid <= w_issue;
        r_out_last  <= w_issue && w_idx_last;
        if (w_issue) begin
          r_out_num <= r_idx;
          r_out     <= (r_state == S_EMIT) ? r_mem[w_rd_addr] : '0;
        end
      end
    end
  end

  assign o_in_ready  = r_in_ready;
  assign o_out       = r_out;
  assign o_out_valid = r_out_valid;
  assign o_out_num   = r_out_num;
  assign o_out_last  = r_out_last;
  assign o_frame_num = r_frame_num;
  assign o_out_state = r_state;

endmodule

// File: tb/tb_kws_framer.sv
// Directed bench for kws_framer: expected frame words are queued when a stream
// is loaded and checked as the framer hands them out.
module tb_kws_framer;

  localparam int DW = 20, FL = 8, HL = 4, PL = 16, AW = 4, NF = 3, NW = 4, FW = 6;

  typedef struct packed {
    logic signed [DW-1:0] d;
    logic [NW-1:0]        num;
    logic                 last;
    logic [FW-1:0]        frm;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 start = 1'b0;
  logic signed [DW-1:0] in_d = '0;
  logic                 in_valid = 1'b0;
  logic                 in_ready;
  logic signed [DW-1:0] out_d;
  logic                 out_valid;
  logic                 out_ready = 1'b1;
  logic [NW-1:0]        out_num;
  logic                 out_last;
  logic [FW-1:0]        frame_num;
  logic [2:0]           out_state;

  int total = 0;
  int bad = 0;
  exp_t sb[$];
  logic signed [DW-1:0] in_q[$];
  logic signed [DW-1:0] stim[$];
  int edge_n = 0;
  int acc_cnt = 0;
  int acc8_edge = -1;
  int acc17_edge = -1;
  int first_v_edge = -1;
  int lastx_edge = -1;

  kws_framer #(
    .DATA_WDTH(DW), .FRAME_LEN(FL), .HOP_LEN(HL), .PAD_LEN(PL),
    .ADDR_WDTH(AW), .NUM_FRAMES(NF), .NUM_WDTH(NW), .FRM_WDTH(FW)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start),
    .i_in(in_d), .i_in_valid(in_valid), .o_in_ready(in_ready),
    .o_out(out_d), .o_out_valid(out_valid), .i_out_ready(out_ready),
    .o_out_num(out_num), .o_out_last(out_last),
    .o_frame_num(frame_num), .o_out_state(out_state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: score any output transfer, let the edge happen, then drive the next input
  task automatic cyc();
    logic acc, xfer, xl;
    exp_t e;
    acc  = in_valid && in_ready;
    xfer = out_valid && out_ready;
    xl   = xfer && out_last;
    if (xfer) begin
      if (sb.size() == 0) begin
        chk("unexpected_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("out_data", out_d, e.d);
        chk("out_num", {28'b0, out_num}, {28'b0, e.num});
        chk("out_last", {31'b0, out_last}, {31'b0, e.last});
        chk("frame_num", {26'b0, frame_num}, {26'b0, e.frm});
      end
    end
    @(posedge clk);
    edge_n++;
    if (acc) begin
      if (in_q.size() != 0) void'(in_q.pop_front());
      acc_cnt++;
      if (acc_cnt == FL) acc8_edge = edge_n;
      if (acc_cnt == 17) acc17_edge = edge_n;
    end
    if (xl && lastx_edge < 0) lastx_edge = edge_n;
    #1;
    if (out_valid && first_v_edge < 0) first_v_edge = edge_n;
    in_valid = (in_q.size() != 0);
    in_d     = in_valid ? in_q[0] : '0;
  endtask

  // Pulse start, queue the stream and the NF padded frames it must produce
  task automatic start_and_load();
    exp_t e;
    acc_cnt = 0; acc8_edge = -1; acc17_edge = -1; first_v_edge = -1; lastx_edge = -1;
    in_q = stim;
    for (int f = 0; f < NF; f++) begin
      for (int i = 0; i < PL; i++) begin
        e.d    = (i < FL) ? stim[f*HL + i] : '0;
        e.num  = NW'(i);
        e.last = (i == PL - 1);
        e.frm  = FW'(f);
        sb.push_back(e);
      end
    end
    start    = 1'b1;
    in_valid = 1'b1;
    in_d     = stim[0];
    cyc();
    start = 1'b0;
  endtask

  task automatic run_done(input string tag, input int bp_at);
    int n;
    bit bp_done;
    n = 0;
    bp_done = 1'b0;
    while (!(sb.size() == 0 && out_state == 3'd4) && n < 400) begin
      if (bp_at >= 0 && !bp_done && out_valid && out_num == NW'(bp_at) && frame_num == '0) begin
        out_ready = 1'b0;
        for (int j = 0; j < 5; j++) begin
          cyc();
          chk("bp_hold_data", out_d, 32'(bp_at + 1));
          chk("bp_hold_num", {28'b0, out_num}, 32'(bp_at));
          n++;
        end
        out_ready = 1'b1;
        bp_done   = 1'b1;
      end
      cyc();
      n++;
    end
    chk({tag, "_reach_done"}, {29'b0, out_state}, 32'd4);
    chk({tag, "_sb_empty"}, 32'(sb.size()), 32'd0);
    in_q.delete();
    in_valid = 1'b0;
    in_d     = '0;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, {29'b0, out_state}, 32'd0);
    chk({tag, "_in_ready"}, {31'b0, in_ready}, 32'd0);
    chk({tag, "_out_valid"}, {31'b0, out_valid}, 32'd0);
    chk({tag, "_out"}, out_d, 32'd0);
    chk({tag, "_out_num"}, {28'b0, out_num}, 32'd0);
    chk({tag, "_out_last"}, {31'b0, out_last}, 32'd0);
    chk({tag, "_frame_num"}, {26'b0, frame_num}, 32'd0);
  endtask

  initial begin
    int n;
    int x;
    logic signed [DW-1:0] v;

    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    rst = 1'b0;
    cyc();

    // Ramp stream, three frames, latency of the first word
    stim.delete();
    for (int i = 1; i <= 20; i++) stim.push_back(DW'(i));
    start_and_load();
    run_done("basic", -1);
    chk("latency", 32'(first_v_edge), 32'(acc8_edge + 2));
    chk("done_in_ready", {31'b0, in_ready}, 32'd0);
    chk("done_out_valid", {31'b0, out_valid}, 32'd0);

    // Backpressure in frame 0 at out_num 3
    stim.delete();
    for (int i = 1; i <= 16; i++) stim.push_back(DW'(i));
    start_and_load();
    chk("rearm_state", {29'b0, out_state}, 32'd1);
    chk("rearm_frame", {26'b0, frame_num}, 32'd0);
    run_done("bp", 3);

    // Full buffer while the output is stalled
    stim.delete();
    for (int i = 1; i <= 20; i++) stim.push_back(DW'(i));
    out_ready = 1'b0;
    start_and_load();
    repeat (40) cyc();
    chk("full_acc_cnt", 32'(acc_cnt), 32'd16);
    chk("full_in_ready", {31'b0, in_ready}, 32'd0);
    chk("full_out_valid", {31'b0, out_valid}, 32'd1);
    chk("full_out_first", out_d, 32'd1);
    out_ready = 1'b1;
    run_done("full", -1);
    chk("full_17th_after_hop", 32'(acc17_edge), 32'(lastx_edge + 1));

    // Signed extremes pass bit-exact
    stim.delete();
    v = -20'sd5;       stim.push_back(v);
    v = 20'sd32767;    stim.push_back(v);
    v = 20'h80000;     stim.push_back(v);
    for (int i = 3; i < 16; i++) begin
      x = (i % 2 != 0) ? -(i * 1111) : i * 2222;
      v = x[DW-1:0];
      stim.push_back(v);
    end
    start_and_load();
    run_done("signed", -1);

    // Re-arm from DONE, then reset in the middle of frame 1
    stim.delete();
    for (int i = 100; i < 120; i++) stim.push_back(DW'(i));
    start_and_load();
    chk("rearm2_state", {29'b0, out_state}, 32'd1);
    chk("rearm2_frame", {26'b0, frame_num}, 32'd0);
    n = 0;
    while (!(out_valid && frame_num == FW'(1) && out_num == NW'(6)) && n < 300) begin
      cyc();
      n++;
    end
    chk("rst_trigger_seen", {31'b0, (n < 300)}, 32'd1);
    chk("pre_rst_out", out_d, 32'd110);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    sb.delete();
    in_q.delete();
    in_valid = 1'b0;
    in_d     = '0;
    repeat (2) cyc();
    rst = 1'b0;
    cyc();
    stim.delete();
    for (int i = 500; i < 516; i++) stim.push_back(DW'(i));
    start_and_load();
    run_done("post_rst", -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/kws_framer.md
Name: kws_framer

Overview:
- Parametrised successor to the KWS front-end framing stage; sits between pre-emphasis and the hamming window / FFT.
- Buffers the pre-emphasised sample stream in a circular RAM and emits overlapping frames of FRAME_LEN samples, advancing by HOP_LEN samples per frame.
- Zero-pads each frame to PAD_LEN for the FFT.
- Adds ready/valid backpressure on both sides, a frame-count limit with re-arm, and frame/sample indices for downstream blocks.

Parameters:
- DATA_WDTH, 20, signed sample width in and out.
- FRAME_LEN, 512, samples per frame.
- HOP_LEN, 256, frame advance in samples; 1 <= HOP_LEN <= FRAME_LEN.
- PAD_LEN, 1024, output frame length (FFT size); PAD_LEN >= FRAME_LEN, power of 2.
- ADDR_WDTH, 10, buffer depth DEPTH = 2^ADDR_WDTH; DEPTH >= FRAME_LEN + HOP_LEN.
- NUM_FRAMES, 49, frames per utterance; 0 = unlimited.
- NUM_WDTH, 10, width of out_num; log2(PAD_LEN).
- FRM_WDTH, 6, width of frame_num.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; arms the block (IDLE/DONE -> FILL).
- in  in  DATA_WDTH  signed input sample.
- in_valid  in  1  input sample present.
- in_ready  out  1  block accepts in this cycle.
- out  out  DATA_WDTH  signed frame sample, or zero in the pad region.
- out_valid  out  1  out is valid.
- out_ready  in  1  downstream accepts out.
- out_num  out  NUM_WDTH  index within the padded frame, 0..PAD_LEN-1.
- out_last  out  1  high with the sample at out_num == PAD_LEN-1.
- frame_num  out  FRM_WDTH  index of the current frame, 0-based.
- out_state  out  3  state encoding: IDLE=0, FILL=1, EMIT=2, PAD=3, DONE=4.

Behaviour:
- Reset values: all outputs 0, state IDLE, wr_ptr = base = stored = 0. Reset mid-frame discards all buffered data.
- Input acceptance: a sample is accepted when in_valid && in_ready. It is written at wr_ptr, then wr_ptr increments mod DEPTH.
- Occupancy: stored is the number of samples from base to wr_ptr.
- in_ready = (state in {FILL, EMIT, PAD}) && stored < DEPTH. in_ready is 0 in IDLE and DONE; samples offered there are ignored.
- IDLE -> FILL on start; wr_ptr, base, stored and frame_num are cleared.
- FILL -> EMIT when stored >= FRAME_LEN; evaluated on registered stored, one cycle after the FRAME_LEN-th acceptance.
- EMIT:
  - Reads RAM[base+idx] with a synchronous 1-cycle RAM, idx = 0..FRAME_LEN-1.
  - First out_valid is asserted 2 cycles after the edge on which the frame's FRAME_LEN-th sample was accepted.
- PAD: drives out = 0 for idx = FRAME_LEN..PAD_LEN-1. If PAD_LEN == FRAME_LEN, PAD is skipped.
- Output handshake:
  - A transfer occurs when out_valid && out_ready.
  - While out_valid && !out_ready, out, out_num, out_last and frame_num hold stable.
  - The read pipeline stalls; no sample is dropped or duplicated.
  - Sustained throughput is 1 sample/cycle with out_ready held high.
- Frame completion, on the transfer with out_last:
  - base += HOP_LEN (mod DEPTH) and stored -= HOP_LEN.
  - frame_num increments.
  - If NUM_FRAMES != 0 and frame_num + 1 == NUM_FRAMES, go to DONE.
  - Otherwise, if the remaining stored >= FRAME_LEN, go to EMIT with no gap beyond the 1-cycle read latency; else go to FILL.
- Simultaneous accept and hop in the same cycle: stored_next = stored + 1 - HOP_LEN.
- Full buffer: stored == DEPTH forces in_ready low. Unread frame data is never overwritten.
- DONE: out_valid = 0, in_ready = 0. A start pulse re-enters FILL with all pointers cleared. start in FILL/EMIT/PAD is ignored.
- Arithmetic: pointers are ADDR_WDTH bits and wrap naturally. stored is ADDR_WDTH+1 bits. Samples pass through bit-exact with no scaling.

Test Plan (params FRAME_LEN=8, HOP_LEN=4, PAD_LEN=16, ADDR_WDTH=4, NUM_FRAMES=3, out_ready=1 unless noted):
- Basic framing: start, then ramp in = 1,2,3,... with in_valid=1.
  - Frame 0 is out = 1..8 then eight 0s, out_num 0..15, out_last at 15.
  - Frame 1 is 5..12 plus pad; frame 2 is 9..16 plus pad.
  - frame_num steps 0,1,2, then out_state=4 and in_ready=0.
- Latency: the 8th sample accepted at edge k produces out_valid rising after edge k+2 with out=1, out_num=0.
- Backpressure: drop out_ready for 5 cycles at out_num=3. out stays 4 with out_num=3, then resumes 5,6,... with no loss or duplication.
- Full buffer: hold out_ready=0 and feed 20 samples. in_ready falls after the 16th acceptance; the 17th sample waits until the hop frees 4 slots.
- Signed data and re-arm: feed -5, 32767 and the 20-bit minimum. These appear unchanged in out and pad words are exactly 0. In DONE, start restarts at frame_num=0.
- Reset mid-operation: assert rst at frame 1, out_num=6. All outputs go to 0 immediately; after release and start, the first frame is built only from new samples.
